// File: rtl/harvard_bus_bridge.sv
// Bridges a stall-free Harvard core onto one shared waitrequest bus.
// Fetch and the optional data access are sequenced, and the core is stepped once per completed instruction.
module harvard_bus_bridge #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 0,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                core_active,
    input  logic [ADDR_W-1:0]   core_instr_address,
    output logic [DATA_W-1:0]   core_instr_readdata,
    input  logic [ADDR_W-1:0]   core_data_address,
    input  logic                core_data_read,
    input  logic                core_data_write,
    input  logic [DATA_W/8-1:0] core_data_byteenable,
    input  logic [DATA_W-1:0]   core_data_writedata,
    output logic [DATA_W-1:0]   core_data_readdata,
    output logic                core_step,
    output logic [ADDR_W-1:0]   bus_address,
    output logic                bus_read,
    output logic                bus_write,
    output logic [DATA_W/8-1:0] bus_byteenable,
    output logic [DATA_W-1:0]   bus_writedata,
    input  logic                bus_waitrequest,
    input  logic [DATA_W-1:0]   bus_readdata,
    output logic                bus_error,
    output logic [CNT_W-1:0]    retired_count
);

    localparam int BE_W = DATA_W / 8;
    localparam logic        TIMEOUT_EN = (MAX_WAIT > 0);
    localparam logic [31:0] WAIT_LAST  = (MAX_WAIT > 0) ? 32'(MAX_WAIT - 1) : 32'd0;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_EXEC   = 3'd1,
        ST_MEM    = 3'd2,
        ST_COMMIT = 3'd3,
        ST_HALTED = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    state_t              state_r, state_next_s;
    logic [31:0]         wait_cnt_r;
    logic                mem_write_r;
    logic [DATA_W-1:0]   instr_r, load_r;
    logic                bus_error_r;
    logic [CNT_W-1:0]    retired_r;

    logic                bus_read_s, bus_write_s, core_step_s;
    logic                xfer_done_s, timeout_hit_s;
    logic [ADDR_W-1:0]   bus_address_s;
    logic [BE_W-1:0]     bus_byteenable_s;
    logic [DATA_W-1:0]   bus_writedata_s;

    // The transfer that just waited its last tolerated cycle never completes.
    assign timeout_hit_s = TIMEOUT_EN && bus_waitrequest && (wait_cnt_r == WAIT_LAST);

    // Next-state and bus/step decode from the current state.
    always_comb begin
        state_next_s     = state_r;
        bus_read_s       = 1'b0;
        bus_write_s      = 1'b0;
        core_step_s      = 1'b0;
        xfer_done_s      = 1'b0;
        bus_address_s    = core_instr_address;
        bus_byteenable_s = {BE_W{1'b1}};
        bus_writedata_s  = core_data_writedata;
        case (state_r)
            ST_FETCH: begin
                if (!core_active) begin
                    state_next_s = ST_HALTED;
                end else begin
                    bus_read_s = 1'b1;
                    if (!bus_waitrequest) begin
                        xfer_done_s  = 1'b1;
                        state_next_s = ST_EXEC;
                    end else if (timeout_hit_s) begin
                        state_next_s = ST_ERROR;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                end
            end
            ST_EXEC: begin
                if (core_data_read || core_data_write) begin
                    state_next_s = ST_MEM;
                end else begin
                    core_step_s  = 1'b1;
                    state_next_s = ST_FETCH;
                end
            end
            ST_MEM: begin
                bus_address_s    = core_data_address;
                bus_byteenable_s = core_data_byteenable;
                bus_write_s      = mem_write_r;
                bus_read_s       = !mem_write_r;
                if (!bus_waitrequest) begin
                    xfer_done_s  = 1'b1;
                    state_next_s = ST_COMMIT;
                end else if (timeout_hit_s) begin
                    state_next_s = ST_ERROR;
                end else begin
                    state_next_s = ST_MEM;
                end
            end
            ST_COMMIT: begin
                core_step_s  = 1'b1;
                state_next_s = ST_FETCH;
            end
            ST_HALTED: state_next_s = ST_HALTED;
            ST_ERROR:  state_next_s = ST_ERROR;
            default:   state_next_s = ST_FETCH;
        endcase
    end

    // State, wait counter, held data words, error flag and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_FETCH;
            wait_cnt_r  <= 32'd0;
            mem_write_r <= 1'b0;
            instr_r     <= {DATA_W{1'b0}};
            load_r      <= {DATA_W{1'b0}};
            bus_error_r <= 1'b0;
            retired_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (xfer_done_s) begin
                wait_cnt_r <= 32'd0;
            end else if ((bus_read_s || bus_write_s) && bus_waitrequest) begin
                wait_cnt_r <= wait_cnt_r + 32'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            // A simultaneous read and write request is treated as a write.
            if (state_r == ST_EXEC) begin
                mem_write_r <= core_data_write;
            end
            if (state_r == ST_FETCH && xfer_done_s) begin
                instr_r <= bus_readdata;
            end
            if (state_r == ST_MEM && xfer_done_s && !mem_write_r) begin
                load_r <= bus_readdata;
            end
            if (state_next_s == ST_ERROR) begin
                bus_error_r <= 1'b1;
            end
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, core_step_s};
        end
    end

    // Strobes and step are forced low while reset is asserted, whatever the state.
    assign bus_read            = bus_read_s  && !reset;
    assign bus_write           = bus_write_s && !reset;
    assign core_step           = core_step_s && !reset;
    assign bus_address         = bus_address_s;
    assign bus_byteenable      = bus_byteenable_s;
    assign bus_writedata       = bus_writedata_s;
    assign core_instr_readdata = instr_r;
    assign core_data_readdata  = load_r;
    assign bus_error           = bus_error_r;
    assign retired_count       = retired_r;

endmodule
